gpu_mem_arbiter: RTL and testbench

- Parametrised arbiter that multiplexes NUM_CH core memory ports onto one single-port shared-memory bank.
- Supports round-robin or fixed-priority mode and a VGA-copy preemption channel that gains exclusive bank ownership.
- Sits between the core array and sh_mem, replacing per-design hard-wired arbitration.
- Buses are channel-packed, with channel i occupying slice [(i+1)*W-1 : i*W].

---
 rtl/gpu_mem_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_gpu_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_mem_arbiter.sv
// Purpose: arbitrates NUM_CH core memory ports onto one single-port shared-memory bank, with VGA preemption.
// Latency: request seen in IDLE at cycle N -> mem_en at N+1, ready at N+2, rd_data slice updated from N+3; 3 cycles per access.
// Backpressure: cores hold enable/addr/wr_data until their ready pulse; VGA ownership stalls all cores until vga_req drops.
module gpu_mem_arbiter #(
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MODE   = 0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2*NUM_CH-1:0]      enable,
  input  logic [ADDR_W*NUM_CH-1:0] addr,
  input  logic [DATA_W*NUM_CH-1:0] wr_data,
  output logic [DATA_W*NUM_CH-1:0] rd_data,
  output logic [NUM_CH-1:0]        ready,
  input  logic                     vga_req,
  output logic                     vga_grant,
  output logic                     mem_en,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_addr,
  output logic [DATA_W-1:0]        mem_wdata,
  input  logic [DATA_W-1:0]        mem_rdata,
  output logic                     busy
);

  localparam int CW  = $clog2(NUM_CH);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    VGA    = 2'd3
  } state_t;

  state_t state, next_state;

  logic [NUM_CH-1:0] req;
  logic              any_req;
  logic [CW-1:0]     win;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              grant_core;

  logic [CW-1:0]     win_idx;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [CW-1:0]     rr_ptr;

  // Per-channel request flags: any non-idle enable code is a request.
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      req[i] = |enable[2*i +: 2];
    end
  end

  assign any_req = |req;

  // Winner pick: rotating scan from rr_ptr, or lowest index in fixed-priority mode.
  always_comb begin
    logic          found;
    logic [CW1-1:0] idx;
    found = 1'b0;
    idx   = '0;
    win   = '0;
    if (MODE == 0) begin
      for (int i = 0; i < NUM_CH; i++) begin
        idx = {1'b0, rr_ptr} + CW1'(i);
        if (idx >= CW1'(NUM_CH)) begin
          idx = idx - CW1'(NUM_CH);
        end
        if (!found && req[idx[CW-1:0]]) begin
          found = 1'b1;
          win   = idx[CW-1:0];
        end
      end
    end else begin
      // Channel 0 always wins; higher channels can starve by design.
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req[i]) begin
          win = CW'(i);
        end
      end
    end
  end

  // Mux out the winning channel's op, address and write data.
  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win == CW'(i)) begin
        // Codes 10 and 11 both mean write.
        sel_we    = enable[2*i+1];
        sel_addr  = addr[i*ADDR_W +: ADDR_W];
        sel_wdata = wr_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // A core is granted only from IDLE and only when VGA is not asking.
  assign grant_core = (state == IDLE) && !vga_req && any_req;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and bank/handshake outputs decoded from the current state.
  always_comb begin
    next_state = state;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    vga_grant  = 1'b0;
    ready      = '0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        if (vga_req) begin
          next_state = VGA;
        end else if (any_req) begin
          next_state = ACCESS;
        end
      end
      ACCESS: begin
        mem_en     = 1'b1;
        mem_we     = lat_we;
        mem_addr   = lat_addr;
        mem_wdata  = lat_wdata;
        next_state = RESP;
      end
      RESP: begin
        for (int i = 0; i < NUM_CH; i++) begin
          ready[i] = (win_idx == CW'(i));
        end
        next_state = IDLE;
      end
      VGA: begin
        // The bank is driven by the VGA path in sh_mem; keep our strobe low.
        vga_grant = 1'b1;
        if (!vga_req) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Latch the winning request so later input changes cannot disturb the access.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_idx   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (grant_core) begin
      win_idx   <= win;
      lat_we    <= sel_we;
      lat_addr  <= sel_addr;
      lat_wdata <= sel_wdata;
    end
  end

  // Round-robin pointer moves past the channel just served; VGA never touches it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr <= '0;
    end else if ((MODE == 0) && (state == RESP)) begin
      rr_ptr <= (win_idx == CW'(NUM_CH - 1)) ? '0 : win_idx + CW'(1);
    end
  end

  // Capture read data into the winner's slice; other slices keep their last value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_data <= '0;
    end else if ((state == RESP) && !lat_we) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (win_idx == CW'(i)) begin
          rd_data[i*DATA_W +: DATA_W] <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_gpu_mem_arbiter.sv
module tb_gpu_mem_arbiter;

  logic        clk;
  logic        reset;

  // Round-robin instance
  logic [7:0]  enable;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic [3:0]  ready;
  logic        vga_req;
  logic        vga_grant;
  logic        mem_en;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        busy;

  // Fixed-priority instance
  logic [7:0]  fp_enable;
  logic [31:0] fp_addr;
  logic [31:0] fp_wr_data;
  logic [31:0] fp_rd_data;
  logic [3:0]  fp_ready;
  logic        fp_vga_req;
  logic        fp_vga_grant;
  logic        fp_mem_en;
  logic        fp_mem_we;
  logic [7:0]  fp_mem_addr;
  logic [7:0]  fp_mem_wdata;
  logic [7:0]  fp_mem_rdata;
  logic        fp_busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0] ch;
    logic       is_rd;
    logic [7:0] a;
    logic [7:0] d;
  } exp_t;

  exp_t exp_q[$];
  logic [7:0] mem [256];

  gpu_mem_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(8), .MODE(0)) dut (
    .clk(clk), .reset(reset), .enable(enable), .addr(addr), .wr_data(wr_data),
    .rd_data(rd_data), .ready(ready), .vga_req(vga_req), .vga_grant(vga_grant),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  gpu_mem_arbiter #(.NUM_CH(4), .ADDR_W(8), .DATA_W(8), .MODE(1)) dut_fp (
    .clk(clk), .reset(reset), .enable(fp_enable), .addr(fp_addr), .wr_data(fp_wr_data),
    .rd_data(fp_rd_data), .ready(fp_ready), .vga_req(fp_vga_req), .vga_grant(fp_vga_grant),
    .mem_en(fp_mem_en), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
    .mem_rdata(fp_mem_rdata), .busy(fp_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // Shared-memory model: one-cycle read latency, write on strobe.
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h5A;
    mem[8'h20] = 8'h11;
    mem[8'h21] = 8'h22;
    mem[8'h22] = 8'h33;
    mem[8'h23] = 8'h44;
    mem_rdata = 8'h00;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        else        mem_rdata = mem[mem_addr];
      end
    end
  end

  // Monitor: pops one expectation per ready pulse and checks the bank access behind it.
  initial begin
    exp_t       e;
    logic       last_en, last_we, pend_rd;
    logic [7:0] last_a, last_d, pend_val;
    int         pend_ch;
    last_en = 1'b0; last_we = 1'b0; last_a = '0; last_d = '0;
    pend_rd = 1'b0; pend_val = '0; pend_ch = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        pend_rd = 1'b0;
        last_en = 1'b0;
      end else begin
        if (pend_rd) begin
          chk($sformatf("mon_rd_data_ch%0d", pend_ch), {24'h0, rd_data[pend_ch*8 +: 8]}, {24'h0, pend_val});
          pend_rd = 1'b0;
        end
        if (ready != 4'b0000) begin
          if (exp_q.size() == 0) begin
            chk("mon_unexpected_ready", {28'h0, ready}, 32'h0);
          end else begin
            e = exp_q.pop_front();
            chk("mon_ready_ch", {28'h0, ready}, 32'h1 << e.ch);
            chk("mon_mem_en_prev", {31'h0, last_en}, 32'h1);
            chk("mon_mem_addr", {24'h0, last_a}, {24'h0, e.a});
            chk("mon_mem_we", {31'h0, last_we}, {31'h0, !e.is_rd});
            if (e.is_rd) begin
              pend_rd  = 1'b1;
              pend_val = e.d;
              pend_ch  = int'(e.ch);
            end else begin
              chk("mon_mem_wdata", {24'h0, last_d}, {24'h0, e.d});
            end
          end
        end
        last_en = mem_en;
        if (mem_en) begin
          last_we = mem_we;
          last_a  = mem_addr;
          last_d  = mem_wdata;
        end
      end
    end
  end

  function automatic void expect_acc(input int ch, input logic is_rd, input logic [7:0] a, input logic [7:0] d);
    exp_t e;
    e.ch = 2'(ch); e.is_rd = is_rd; e.a = a; e.d = d;
    exp_q.push_back(e);
  endfunction

  task automatic set_ch(input int ch, input logic [1:0] op, input logic [7:0] a, input logic [7:0] d);
    enable[2*ch +: 2] = op;
    addr[8*ch +: 8]   = a;
    wr_data[8*ch +: 8] = d;
  endtask

  // Run until every core has been served, dropping each enable on its ready pulse.
  task automatic drain(input string nm);
    int n;
    n = 0;
    while (enable != 8'h00 && n < 40) begin
      @(negedge clk);
      n++;
      for (int i = 0; i < 4; i++) begin
        if (ready[i]) enable[2*i +: 2] = 2'b00;
      end
    end
    if (enable != 8'h00) chk({nm, "_drain_timeout"}, {24'h0, enable}, 32'h0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int k;
    int cnt0;
    int n;
    reset = 1'b0; vga_req = 1'b0;
    enable = '0; addr = '0; wr_data = '0;
    fp_enable = '0; fp_addr = '0; fp_wr_data = '0; fp_vga_req = 1'b0; fp_mem_rdata = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {28'h0, ready}, 32'h0);
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_vga_grant", {31'h0, vga_grant}, 32'h0);
    chk("rst_mem_en", {31'h0, mem_en}, 32'h0);
    chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
    chk("rst_mem_addr", {24'h0, mem_addr}, 32'h0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    // All four request at once from rr_ptr = 0: served 0,1,2,3
    expect_acc(0, 1'b1, 8'h20, 8'h11);
    expect_acc(1, 1'b1, 8'h21, 8'h22);
    expect_acc(2, 1'b1, 8'h22, 8'h33);
    expect_acc(3, 1'b1, 8'h23, 8'h44);
    set_ch(0, 2'b01, 8'h20, 8'h00);
    set_ch(1, 2'b01, 8'h21, 8'h00);
    set_ch(2, 2'b01, 8'h22, 8'h00);
    set_ch(3, 2'b01, 8'h23, 8'h00);
    drain("rr_all4");

    // Pointer wrapped to 0: channel 0 served next, pointer then 1
    expect_acc(0, 1'b1, 8'h20, 8'h11);
    set_ch(0, 2'b01, 8'h20, 8'h00);
    drain("rr_ch0_again");

    // With pointer at 1, channel 1 beats channel 0
    expect_acc(1, 1'b1, 8'h21, 8'h22);
    expect_acc(0, 1'b1, 8'h22, 8'h33);
    set_ch(0, 2'b01, 8'h22, 8'h00);
    set_ch(1, 2'b01, 8'h21, 8'h00);
    drain("rr_ptr_is_1");

    // Write then read back through another channel (11 counts as write)
    expect_acc(0, 1'b0, 8'h3F, 8'hA5);
    set_ch(0, 2'b11, 8'h3F, 8'hA5);
    drain("wr_3f");
    expect_acc(1, 1'b1, 8'h3F, 8'hA5);
    set_ch(1, 2'b01, 8'h3F, 8'h00);
    drain("rd_3f");

    // Single read with exact latency
    expect_acc(2, 1'b1, 8'h10, 8'h5A);
    set_ch(2, 2'b01, 8'h10, 8'h00);
    @(negedge clk);
    chk("lat_mem_en_n1", {31'h0, mem_en}, 32'h1);
    chk("lat_mem_addr_n1", {24'h0, mem_addr}, 32'h10);
    chk("lat_busy_n1", {31'h0, busy}, 32'h1);
    @(negedge clk);
    chk("lat_ready_n2", {28'h0, ready}, 32'h4);
    set_ch(2, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    chk("lat_rd_data_ch2", {24'h0, rd_data[23:16]}, 32'h5A);
    @(negedge clk);

    // VGA request arrives during a channel-1 write; channel 3 queues behind it
    expect_acc(1, 1'b0, 8'h40, 8'h55);
    expect_acc(3, 1'b1, 8'h23, 8'h44);
    set_ch(1, 2'b10, 8'h40, 8'h55);
    @(negedge clk);
    vga_req = 1'b1;
    set_ch(3, 2'b01, 8'h23, 8'h00);
    @(negedge clk);
    chk("vga_inflight_ready1", {28'h0, ready}, 32'h2);
    set_ch(1, 2'b00, 8'h00, 8'h00);
    k = 0;
    while (!vga_grant && k < 3) begin
      @(negedge clk);
      k++;
    end
    chk("vga_grant_rise", {31'h0, vga_grant}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      chk("vga_mem_en_low", {31'h0, mem_en}, 32'h0);
      chk("vga_no_ready", {28'h0, ready}, 32'h0);
      @(negedge clk);
    end
    chk("vga_wr_landed", {24'h0, mem[8'h40]}, 32'h55);
    vga_req = 1'b0;
    @(negedge clk);
    chk("vga_grant_fall", {31'h0, vga_grant}, 32'h0);
    drain("vga_resume_ch3");

    // Serve channel 1 so the pointer sits at 2 before the reset test
    expect_acc(1, 1'b1, 8'h21, 8'h22);
    set_ch(1, 2'b01, 8'h21, 8'h00);
    drain("pre_reset_ch1");

    // Reset during ACCESS aborts the write
    set_ch(0, 2'b10, 8'h77, 8'h11);
    @(negedge clk);
    chk("abort_in_access", {31'h0, mem_en}, 32'h1);
    reset = 1'b0;
    #1;
    chk("abort_mem_en", {31'h0, mem_en}, 32'h0);
    chk("abort_mem_we", {31'h0, mem_we}, 32'h0);
    chk("abort_mem_addr", {24'h0, mem_addr}, 32'h0);
    chk("abort_mem_wdata", {24'h0, mem_wdata}, 32'h0);
    chk("abort_busy", {31'h0, busy}, 32'h0);
    chk("abort_rd_data", rd_data, 32'h0);
    set_ch(0, 2'b00, 8'h00, 8'h00);
    @(negedge clk);
    chk("abort_no_ready", {28'h0, ready}, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_no_write", {24'h0, mem[8'h77]}, 32'h0);
    chk("post_reset_idle", {31'h0, busy}, 32'h0);

    // Pointer back at 0: channel 1 wins over channel 2
    expect_acc(1, 1'b1, 8'h20, 8'h11);
    expect_acc(2, 1'b1, 8'h22, 8'h33);
    set_ch(1, 2'b01, 8'h20, 8'h00);
    set_ch(2, 2'b01, 8'h22, 8'h00);
    drain("post_reset_rr");

    // Fixed priority: channels 0 and 3 held continuously, only 0 is served
    fp_enable = 8'b01_00_00_01;
    fp_addr   = 32'h05_00_00_04;
    cnt0 = 0;
    n = 0;
    while (cnt0 < 20 && n < 100) begin
      @(negedge clk);
      n++;
      if (fp_ready != 4'b0000) begin
        chk("fp_ready_ch0_only", {28'h0, fp_ready}, 32'h1);
        cnt0++;
      end
    end
    chk("fp_grant_count", cnt0, 20);
    chk("fp_cycles_for_20", n, 59);
    fp_enable = 8'h00;
    repeat (3) @(negedge clk);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
